// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch queue.
//   ifetch_state_t : fetch control states
//   fetch_entry_t  : one prefetch FIFO entry {instr, pc, err}
//   INSTR_BYTES    : fetch stride in bytes
package ifetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned INSTR_W     = 32;
  // Entries carry the widest supported PC; narrower builds zero-extend.
  localparam int unsigned PC_MAX_W    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_MAX_W-1:0] pc;
    logic                err;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction-memory port and decode-side instruction port.
//   master : the fetch unit (drives imem_req/imem_addr and the instr_* head)
//   slave  : memory + decode environment
interface ifetch_queue_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            imem_err;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] instr_pc;
  logic            instr_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output instr_valid, instruction, instr_pc, instr_err,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  instr_valid, instruction, instr_pc, instr_err,
    output instr_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small synchronous FIFO with clear, occupancy count and a head
// read straight from the storage flops.
//   i_push/i_push_data : write (accepted when not full, or full with a pop)
//   i_pop              : remove head (ignored when empty)
//   i_clear            : drop all entries; wins over push/pop
//   o_count            : occupancy, o_head : current head entry
module ifetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  // A push into a full FIFO is legal only alongside a pop.
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit with prefetch FIFO for the front end.
// Keeps up to MAX_OUT in-order imem requests in flight, buffers responses with
// their PC in a DEPTH-entry FIFO, and on redirect flushes the FIFO and drops
// stale in-flight responses.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   i_fetch_en         : permits fetching
//   i_redirect_valid   : one-cycle redirect/flush strobe
//   i_redirect_pc      : new fetch PC (low two bits ignored)
//   bus (master)       : imem req/gnt/rvalid port and instr_* decode port
//   o_perf_fetched     : FIFO pushes           (only with IFETCH_PERF_EN)
//   o_perf_discarded   : dropped responses     (only with IFETCH_PERF_EN)
//   o_perf_stall       : FETCH cycles, no req  (only with IFETCH_PERF_EN)
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_fetch_en,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  ifetch_queue_if.master  bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_discarded,
  output logic [31:0]     o_perf_stall
`endif
);
  localparam int unsigned FCW = $clog2(DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUT + 1);

  ifetch_state_t   r_state;
  ifetch_state_t   w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [OCW-1:0]  r_discard_cnt;
  logic [OCW-1:0]  w_out_cnt;
  logic [FCW-1:0]  w_fifo_cnt;
  logic [XLEN-1:0] w_rsp_pc;
  logic            w_req;
  logic            w_grant;
  logic            w_keep;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Credit check: every granted request is guaranteed a FIFO slot on return.
  assign w_req   = (r_state == FETCH) && !i_redirect_valid &&
                   (32'(w_out_cnt) < MAX_OUT) &&
                   ((32'(w_out_cnt) + 32'(w_fifo_cnt)) < DEPTH);
  assign w_grant = w_req && bus.imem_gnt;
  assign w_keep  = bus.imem_rvalid && !i_redirect_valid && (r_discard_cnt == '0);
  assign w_pop   = bus.instr_valid && bus.instr_ready;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.instr = bus.imem_rdata;
    w_push_entry.pc    = PC_MAX_W'(w_rsp_pc);
    w_push_entry.err   = bus.imem_err;
  end

  // Prefetch FIFO; a redirect clears it and overrides any same-cycle pop.
  ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_pfq (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_keep),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_clear     (i_redirect_valid),
    .o_count     (w_fifo_cnt),
    .o_head      (w_head)
  );

  // In-flight PC queue; its occupancy is the outstanding-request count.
  // Never cleared: stale responses still retire their entries.
  ifetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pcq (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_grant),
    .i_push_data (r_fetch_pc),
    .i_pop       (bus.imem_rvalid),
    .i_clear     (1'b0),
    .o_count     (w_out_cnt),
    .o_head      (w_rsp_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state; a queued fault halts fetching until the next redirect.
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect_valid) begin
      w_state_nxt = i_fetch_en ? FETCH : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_fetch_en) w_state_nxt = FETCH;
        FETCH: begin
          if (w_keep && bus.imem_err) w_state_nxt = HALT;
          else if (!i_fetch_en)       w_state_nxt = IDLE;
        end
        HALT:    w_state_nxt = HALT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Fetch PC and count of stale responses still to be dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc    <= RESET_PC;
      r_discard_cnt <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc    <= i_redirect_pc & ~XLEN'(INSTR_BYTES - 1);
      r_discard_cnt <= w_out_cnt - OCW'(bus.imem_rvalid);
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
      if (bus.imem_rvalid && (r_discard_cnt != '0))
        r_discard_cnt <= r_discard_cnt - OCW'(1);
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = (w_fifo_cnt != '0);
  assign bus.instruction = w_head.instr;
  assign bus.instr_pc    = XLEN'(w_head.pc);
  assign bus.instr_err   = w_head.err;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_discarded;
  logic [31:0] r_perf_stall;

  // Free-running event counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_fetched   <= '0;
      r_perf_discarded <= '0;
      r_perf_stall     <= '0;
    end else begin
      if (w_keep) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (bus.imem_rvalid && !w_keep) r_perf_discarded <= r_perf_discarded + 32'd1;
      if ((r_state == FETCH) && !w_req) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_fetched   = r_perf_fetched;
  assign o_perf_discarded = r_perf_discarded;
  assign o_perf_stall     = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus randomized traffic for ifetch_queue,
// checked every cycle against a transaction-level model (request/response
// queues tagged by redirect epoch, expected-instruction FIFO as a queue).
module tb_ifetch_queue;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [63:0] RESET_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded, perf_stall;
`endif

  ifetch_queue_if #(.XLEN(XLEN)) bus ();

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .i_fetch_en       (fetch_en),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .bus              (bus)
`ifdef IFETCH_PERF_EN
    ,
    .o_perf_fetched   (perf_fetched),
    .o_perf_discarded (perf_discarded),
    .o_perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; int epoch; int due; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; logic err; } ent_t;
  typedef struct { logic [63:0] pc; logic err; } dlv_t;

  req_t        memq[$];   // granted, not yet answered
  ent_t        fq[$];     // expected prefetch FIFO contents
  dlv_t        dlv[$];    // deliveries seen at the decode port
  int          mode;      // 0 idle, 1 fetching, 2 halted
  logic [63:0] m_pc;
  int          epoch;
  int          cyc;
  int          gnt_pct, lat_min, lat_max;
  logic [63:0] err_pc;
  logic        err_rand_en;
  logic        s_req, s_valid;
  logic [63:0] s_addr, s_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] m_fetched, m_disc, m_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  function automatic logic mem_fault(input logic [63:0] a);
    return (a == err_pc) || (err_rand_en && (a[9:2] == 8'h3C));
  endfunction

  function automatic logic [63:0] dlv_pc(input int i);
    return (dlv.size() > i) ? dlv[i].pc : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic logic dlv_err(input int i);
    return (dlv.size() > i) ? dlv[i].err : 1'bx;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input logic redir, input logic [63:0] tgt, input logic fen, input logic rdy);
    logic exp_req, gnt, rv, keep, fault;
    req_t h;
    ent_t e;
    redirect_valid  = redir;
    redirect_pc     = tgt;
    fetch_en        = fen;
    bus.instr_ready = rdy;
    gnt             = ($urandom_range(99) < gnt_pct);
    bus.imem_gnt    = gnt;
    rv              = (memq.size() > 0) && (memq[0].due <= cyc);
    bus.imem_rvalid = rv;
    if (rv) begin
      h              = memq[0];
      bus.imem_rdata = mem_word(h.pc);
      bus.imem_err   = mem_fault(h.pc);
    end else begin
      h              = '{pc: '0, epoch: -1, due: 0};
      bus.imem_rdata = $urandom;
      bus.imem_err   = 1'($urandom_range(1));
    end
    #4;
    exp_req = (mode == 1) && !redir && (memq.size() < MAX_OUT) &&
              (memq.size() + fq.size() < DEPTH);
    s_req = bus.imem_req; s_addr = bus.imem_addr;
    s_valid = bus.instr_valid; s_pc = bus.instr_pc;
    check_eq("imem_req", bus.imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", bus.imem_addr, m_pc);
    check_eq("instr_valid", bus.instr_valid, fq.size() != 0);
    if (fq.size() != 0) begin
      check_eq("instr_pc", bus.instr_pc, fq[0].pc);
      check_eq("instruction", bus.instruction, fq[0].instr);
      check_eq("instr_err", bus.instr_err, fq[0].err);
    end
`ifdef IFETCH_PERF_EN
    check_eq("perf_fetched", perf_fetched, m_fetched);
    check_eq("perf_discarded", perf_discarded, m_disc);
    check_eq("perf_stall", perf_stall, m_stall);
`endif
    if (bus.instr_valid && rdy && !redir) dlv.push_back('{pc: bus.instr_pc, err: bus.instr_err});
    @(posedge clk);
    keep  = rv && !redir && (h.epoch == epoch);
    fault = keep && mem_fault(h.pc);
    if (rv) void'(memq.pop_front());
`ifdef IFETCH_PERF_EN
    if (rv && !keep) m_disc++;
    if (mode == 1 && !exp_req) m_stall++;
    if (keep) m_fetched++;
`endif
    if (redir) begin
      fq.delete();
      epoch++;
      m_pc = {tgt[63:2], 2'b00};
      mode = fen ? 1 : 0;
    end else begin
      if (fq.size() != 0 && rdy) void'(fq.pop_front());
      if (keep) begin
        e = '{pc: h.pc, instr: mem_word(h.pc), err: mem_fault(h.pc)};
        fq.push_back(e);
      end
      if (exp_req && gnt) begin
        memq.push_back('{pc: m_pc, epoch: epoch, due: cyc + $urandom_range(lat_max, lat_min)});
        m_pc = m_pc + 64'd4;
      end
      if (mode == 0 && fen) mode = 1;
      else if (mode == 1) begin
        if (fault)     mode = 2;
        else if (!fen) mode = 0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic [63:0] tgt;
    resetn = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.imem_err = 1'b0; bus.instr_ready = 1'b0;
    mode = 0; m_pc = RESET_PC; epoch = 0; cyc = 0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; err_pc = 64'h1; err_rand_en = 1'b0;
`ifdef IFETCH_PERF_EN
    m_fetched = '0; m_disc = '0; m_stall = '0;
`endif
    #12;
    check_eq("rst_imem_req", bus.imem_req, 1'b0);
    check_eq("rst_imem_addr", bus.imem_addr, 64'h1000);
    check_eq("rst_instr_valid", bus.instr_valid, 1'b0);
    check_eq("rst_instruction", bus.instruction, 32'h0);
    check_eq("rst_instr_pc", bus.instr_pc, 64'h0);
    check_eq("rst_instr_err", bus.instr_err, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Streaming at one instruction per cycle from RESET_PC.
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (k >= 3) begin
        check_eq("tp1_valid", s_valid, 1'b1);
        check_eq("tp1_pc", s_pc, 64'h1000 + 64'(4 * (k - 3)));
      end
    end

    // Decode stalled: FIFO fills, requests stop, then drains in order.
    step(1'b1, 64'h1000, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("tp2_req_low", s_req, 1'b0);
    check_eq("tp2_head_pc", s_pc, 64'h1000);
    dlv.delete();
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) check_eq("tp2_drain_pc", dlv_pc(i), 64'h1000 + 64'(4 * i));

    // Slow memory, redirect with requests in flight.
    lat_min = 3; lat_max = 3;
    step(1'b1, 64'h1000, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, '0, 1'b1, 1'b1);
    dlv.delete();
    step(1'b1, 64'h2000, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b1);
    check_eq("tp3_first_pc", dlv_pc(0), 64'h2000);

    // Redirect coinciding with a response and a decode pop.
    lat_min = 1; lat_max = 1;
    step(1'b1, 64'h1000, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b1);
    dlv.delete();
    step(1'b1, 64'h2000, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("tp4_valid_after_redirect", s_valid, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, 1'b1);
    check_eq("tp4_first_pc", dlv_pc(0), 64'h2000);

    // Fetch fault halts fetching; redirect resumes.
    err_pc = 64'h1008;
    step(1'b1, 64'h1000, 1'b1, 1'b1);
    dlv.delete();
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b1);
    check_eq("tp5_fault_pc", dlv_pc(2), 64'h1008);
    check_eq("tp5_fault_err", dlv_err(2), 1'b1);
    check_eq("tp5_ok_err", dlv_err(0), 1'b0);
    check_eq("tp5_halt_req", s_req, 1'b0);
    step(1'b1, 64'h3000, 1'b1, 1'b1);
    dlv.delete();
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b1);
    check_eq("tp5_resume_pc", dlv_pc(0), 64'h3000);
    err_pc = 64'h1;

    // Address wrap at the top of the 64-bit space (low bits forced to zero).
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("tp6_req", s_req, 1'b1);
    check_eq("tp6_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("tp6_addr_wrap", s_addr, 64'h0);

    // Randomized traffic.
    gnt_pct = 70; lat_min = 1; lat_max = 4; err_rand_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else                        tgt = {32'($urandom), 32'($urandom)};
      step($urandom_range(99) < 3, tgt, $urandom_range(99) < 95, $urandom_range(99) < 70);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction fetch unit with a prefetch queue, for the RISC-V pipeline front end between the PC/redirect logic and decode. It keeps up to MAX_OUT memory requests in flight with an in-order valid/ready instruction memory port. Returned instructions are buffered with their PC in a DEPTH-entry FIFO. Redirects flush the queue and silently discard stale in-flight responses.

## Interface
- XLEN, 64: address/PC width (32 or 64).
- DEPTH, 4: prefetch FIFO entries, power of two, ≥2.
- MAX_OUT, 2: max outstanding imem requests, 1..DEPTH.
- RESET_PC, 0: fetch PC after reset, XLEN bits.

- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits fetching; low holds in IDLE.
- redirect_valid  in  1  one-cycle redirect/flush strobe.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] forced to 0.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address.
- imem_gnt  in  1  request accepted when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid, in request order, ≥1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- imem_err  in  1  response carries access fault, qualified by imem_rvalid.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head when instr_valid && instr_ready.
- instruction  out  32  head instruction.
- instr_pc  out  XLEN  head PC.
- instr_err  out  1  head is a fetch fault.

## Operation
- FSM states:
  - IDLE: no requests.
  - FETCH: issuing requests.
  - HALT: after a fault was queued; no requests until redirect.
- Transitions:
  - IDLE→FETCH when fetch_en.
  - FETCH→IDLE when !fetch_en.
  - FETCH→HALT on an accepted non-discarded response with imem_err.
  - Any state→FETCH on redirect_valid && fetch_en; otherwise →IDLE.
- imem_req = FETCH && !redirect_valid && outstanding < MAX_OUT && (outstanding + fifo_count) < DEPTH.
  - Combinational from registers and redirect_valid only; never from imem_gnt.
  - Credit check guarantees every response has a FIFO slot; there is no response backpressure.
- imem_addr = fetch_pc. On grant, fetch_pc += 4, wrapping modulo 2^XLEN.
- Each granted address is pushed into an in-flight PC queue (MAX_OUT entries), popped on every imem_rvalid.
- On a response:
  - discard_cnt > 0: drop it and decrement discard_cnt.
  - Otherwise: push {imem_rdata, popped PC, imem_err} into the FIFO.
- On redirect:
  - fetch_pc ← redirect_pc.
  - FIFO cleared.
  - discard_cnt ← outstanding − (imem_rvalid this cycle ? 1 : 0).
  - A same-cycle response is dropped.
  - A same-cycle pop is ignored.
- While discarding, new requests may issue. Responses stay ordered, so the first response after discard_cnt reaches 0 belongs to the new stream.
- Simultaneous push and pop with a full FIFO is legal; count is unchanged.
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instruction 0, instr_pc 0, instr_err 0. After reset: state IDLE, counts 0, fetch_pc RESET_PC.
- Reset mid-operation abandons in-flight requests. The memory side is reset together with this block.

## Timing
- First imem_req: cycle after fetch_en is sampled high in IDLE.
- Grant at cycle N, rvalid at N+1 gives instr_valid at N+2 (FIFO output registered).
- Sustained throughput: 1 instr/cycle when MAX_OUT ≥ 2 and memory latency is 1.
- redirect_valid at cycle R:
  - instr_valid is 0 at R+1.
  - First new-stream imem_req at R+1.
- instr_valid/instruction/instr_pc/instr_err stay stable while instr_valid && !instr_ready.

## Configuration
- IFETCH_PERF_EN defined: adds three 32-bit output ports, each wrapping and reset to 0:
  - perf_fetched: FIFO pushes.
  - perf_discarded: dropped responses.
  - perf_stall: cycles in FETCH with imem_req low.
- IFETCH_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package ifetch_pkg:
  - ifetch_state_t enum {IDLE, FETCH, HALT}.
  - fetch entry struct {instr, pc, err}.
  - INSTR_BYTES = 4.
- Sub-module ifetch_fifo (parametrised WIDTH, DEPTH; push/pop/clear, count, registered head). Instantiated twice: prefetch FIFO and in-flight PC queue.

## Test plan
- Reset, fetch_en=1, RESET_PC=0x1000, 1-cycle memory, instr_ready=1 → instr_pc 0x1000, 0x1004, 0x1008 on consecutive cycles from cycle 3.
- instr_ready=0, DEPTH=4 → exactly 4 entries queued, imem_req low. Release → 0x1000..0x100C delivered in order with no loss.
- 3-cycle memory latency, 2 outstanding, redirect to 0x2000 → both stale responses dropped. First instr_pc is 0x2000; perf_discarded=2 when IFETCH_PERF_EN.
- redirect coinciding with imem_rvalid and an instr_ready pop → that response dropped. instr_valid=0 next cycle; next delivered pc 0x2000.
- Response for 0x1008 with imem_err=1 → entry delivered with instr_err=1, state HALT, no further imem_req. Redirect to 0x3000 resumes fetching.
- fetch_pc 0xFFFF_FFFF_FFFF_FFFC (XLEN=64) → next imem_addr 0x0.
